multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multi-cycle RV32I core. Sequences IF/ID/EXE/MEM/WB per instruction and drives every datapath enable/select, including ExtSel to the immediate generator.
//  Sits between the IR fields / ALU flags and the PC, IR, register file, ALU, immediate generator and data memory.
//  Counts retired instructions.
// PARAMETERS
//  HALT_OPCODE  7'h7f  opcode that parks the FSM in HALT until reset
//  CNT_W        32     width of retired-instruction counter
// PORTS
//  CLK       in   1      clock; all state changes on rising edge
//  Reset     in   1      asynchronous, active-low reset
//  opcode    in   7      IR[6:0], held stable by IR from ID onward
//  funct3    in   3      IR[14:12]
//  funct7b5  in   1      IR[30]
//  zero      in   1      ALU result == 0
//  lt        in   1      signed A<B
//  ltu       in   1      unsigned A<B
//  dmem_rdy  in   1      data memory done (load/store handshake)
//  PCWre     out  1      PC load enable
//  PCSrc     out  2      0 PC+4, 1 PC+imm, 2 ALU result & ~1 (JALR)
//  IRWre     out  1      IR load enable
//  RegWre    out  1      register-file write enable
//  ExtSel    out  1      1 sign-extend immediate, 0 zero-extend
//  ALUSrcA   out  1      0 rs1, 1 PC
//  ALUSrcB   out  1      0 rs2, 1 imm
//  ALUOp     out  4      0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  MemRd     out  1      data-memory read strobe
//  MemWr     out  1      data-memory write strobe
//  WBSel     out  2      0 ALU, 1 mem data, 2 PC+4
//  state     out  3      0 IF,1 ID,2 EXE,3 MEM,4 WB,7 HALT
//  illegal   out  1      sticky: unsupported opcode/funct3 seen
//  inst_cnt  out  CNT_W  retired instructions, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset low (any time, mid-instruction included): state=IF, inst_cnt=0, illegal=0. Outputs take IF decode: IRWre=1, all other enables 0, selects 0.
//  - State is registered; all outputs are combinational decode of state+opcode/funct fields. The FSM emits no glitch-sensitive strobes.
//  - Sequences:
//    - OP/OP-IMM/LUI/AUIPC/JAL/JALR: IF->ID->EXE->WB->IF
//    - LOAD: IF->ID->EXE->MEM->WB->IF
//    - STORE: IF->ID->EXE->MEM->IF
//    - BRANCH: IF->ID->EXE->IF
//  - IF: IRWre=1 only. ID: no enables (reg read). EXE: ALU operands/ALUOp valid.
//  - MEM: MemRd (load) or MemWr (store) held high until dmem_rdy=1. Wait states are unbounded. dmem_rdy sampled in the same cycle as the strobe.
//  - Retire state (WB; MEM for store; EXE for branch): PCWre=1 for exactly one cycle, inst_cnt+1 at that edge.
//  - PCSrc:
//    - JAL, or branch taken: 1. JALR: 2. Else 0.
//    - Branch taken: funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
//    - Branch not taken still retires with PCSrc=0.
//  - WB: RegWre=1.
//    - WBSel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
//    - Store/branch never assert RegWre.
//  - ALU control:
//    - ALUSrcB=1 for all but OP/BRANCH. ALUSrcA=1 for AUIPC/JAL.
//    - ALUOp: funct3 decode for OP/OP-IMM, with SUB/SRA when funct7b5=1; OP-IMM ignores funct7b5 except shifts.
//    - BRANCH=SUB; LUI=PASSB; LOAD/STORE/AUIPC/JAL/JALR=ADD.
//  - ExtSel=0 for LUI/AUIPC, 1 for all other opcodes; constant across states of an instruction.
//  - Illegal (opcode not in the set above, or BRANCH funct3 010/011): ID->HALT, illegal=1.
//  - HALT_OPCODE: ID->HALT, illegal stays 0. In HALT all enables 0; exit only by reset. inst_cnt does not count halting instruction.
// TESTING
//  - Reset low mid-EXE -> next cycle state=0, IRWre=1, PCWre=0, inst_cnt=0; release -> ID on next edge.
//  - ADDI (opcode 0010011, f3 000) -> states 0,1,2,4,0; RegWre=1 only in WB; ALUOp=0, ALUSrcB=1, ExtSel=1; inst_cnt 0->1.
//  - LW with dmem_rdy low 3 cycles -> MemRd high 4 cycles in MEM, then WB with WBSel=1; total 8 cycles.
//  - BNE (f3 001), zero=0 -> EXE PCWre=1, PCSrc=1; zero=1 -> PCSrc=0; 3 cycles, RegWre never 1.
//  - LUI -> ExtSel=0, ALUOp=10; JALR -> PCSrc=2, WBSel=2, RegWre=1 in WB.
//  - opcode 7'h0b -> HALT (state 7), illegal=1, no further PCWre; opcode 7'h7f -> HALT, illegal=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core.
// Walks each instruction through IF/ID/EXE/MEM/WB and decodes every datapath
// enable and select from the current state plus the IR opcode/funct fields.
// It also keeps a sticky illegal-instruction flag and a retired-instruction counter.
module multicycle_ctrl #(
    parameter logic [6:0] HALT_OPCODE = 7'h7f,
    parameter int         CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             dmem_rdy,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             RegWre,
    output logic             ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             MemRd,
    output logic             MemWr,
    output logic [1:0]       WBSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_IMM = 2'd1;
    localparam logic [1:0] PC_ALU = 2'd2;

    state_t     state_r;
    logic       is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_branch_s;
    logic       is_load_s, is_store_s, is_opimm_s, is_op_s, is_halt_s;
    logic       legal_s, taken_s, ext_s, srca_s, srcb_s;
    logic [3:0] aluop_s;

    assign state = state_r;

    // Opcode class flags, legality and branch condition from IR fields and ALU flags.
    always_comb begin
        is_lui_s    = (opcode == OPC_LUI);
        is_auipc_s  = (opcode == OPC_AUIPC);
        is_jal_s    = (opcode == OPC_JAL);
        is_jalr_s   = (opcode == OPC_JALR);
        is_branch_s = (opcode == OPC_BRANCH);
        is_load_s   = (opcode == OPC_LOAD);
        is_store_s  = (opcode == OPC_STORE);
        is_opimm_s  = (opcode == OPC_OPIMM);
        is_op_s     = (opcode == OPC_OP);
        is_halt_s   = (opcode == HALT_OPCODE);
        legal_s     = is_lui_s | is_auipc_s | is_jal_s | is_jalr_s | is_load_s |
                      is_store_s | is_opimm_s | is_op_s |
                      (is_branch_s & (funct3 != 3'b010) & (funct3 != 3'b011));
        case (funct3)
            3'b000:  taken_s = zero;
            3'b001:  taken_s = ~zero;
            3'b100:  taken_s = lt;
            3'b101:  taken_s = ~lt;
            3'b110:  taken_s = ltu;
            3'b111:  taken_s = ~ltu;
            default: taken_s = 1'b0;
        endcase
    end

    // ALU operand selects, opcode and immediate extension for the current instruction.
    always_comb begin
        ext_s   = ~(is_lui_s | is_auipc_s);
        srca_s  = is_auipc_s | is_jal_s;
        srcb_s  = ~(is_op_s | is_branch_s);
        aluop_s = ALU_ADD;
        if (is_op_s || is_opimm_s) begin
            case (funct3)
                3'b000:  aluop_s = (is_op_s && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  aluop_s = ALU_SLL;
                3'b010:  aluop_s = ALU_SLT;
                3'b011:  aluop_s = ALU_SLTU;
                3'b100:  aluop_s = ALU_XOR;
                3'b101:  aluop_s = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  aluop_s = ALU_OR;
                3'b111:  aluop_s = ALU_AND;
                default: aluop_s = ALU_ADD;
            endcase
        end else if (is_branch_s) begin
            aluop_s = ALU_SUB;
        end else if (is_lui_s) begin
            aluop_s = ALU_PASSB;
        end else begin
            aluop_s = ALU_ADD;
        end
    end

    // Datapath control decode; PCWre doubles as the retire pulse for the counter.
    always_comb begin
        PCWre   = 1'b0;
        PCSrc   = PC_SEQ;
        IRWre   = 1'b0;
        RegWre  = 1'b0;
        ExtSel  = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 1'b0;
        ALUOp   = ALU_ADD;
        MemRd   = 1'b0;
        MemWr   = 1'b0;
        WBSel   = 2'd0;
        // Immediate/ALU selects stay constant once IR holds the instruction.
        if (state_r inside {S_ID, S_EXE, S_MEM, S_WB}) begin
            ExtSel  = ext_s;
            ALUSrcA = srca_s;
            ALUSrcB = srcb_s;
            ALUOp   = aluop_s;
        end else begin
            ExtSel  = 1'b0;
        end
        case (state_r)
            S_IF:  IRWre = 1'b1;
            S_ID:  IRWre = 1'b0;
            S_EXE: begin
                if (is_branch_s) begin
                    PCWre = 1'b1;
                    PCSrc = taken_s ? PC_IMM : PC_SEQ;
                end else begin
                    PCWre = 1'b0;
                end
            end
            S_MEM: begin
                if (is_load_s) begin
                    MemRd = 1'b1;
                end else if (is_store_s) begin
                    MemWr = 1'b1;
                    PCWre = dmem_rdy;
                end else begin
                    MemRd = 1'b0;
                end
            end
            S_WB: begin
                RegWre = 1'b1;
                PCWre  = 1'b1;
                if (is_jal_s) begin
                    PCSrc = PC_IMM;
                end else if (is_jalr_s) begin
                    PCSrc = PC_ALU;
                end else begin
                    PCSrc = PC_SEQ;
                end
                if (is_load_s) begin
                    WBSel = 2'd1;
                end else if (is_jal_s || is_jalr_s) begin
                    WBSel = 2'd2;
                end else begin
                    WBSel = 2'd0;
                end
            end
            S_HALT:  PCWre = 1'b0;
            default: PCWre = 1'b0;
        endcase
    end

    // Instruction sequencing and the sticky illegal flag.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IF;
            illegal <= 1'b0;
        end else begin
            case (state_r)
                S_IF: state_r <= S_ID;
                S_ID: begin
                    if (is_halt_s) begin
                        state_r <= S_HALT;
                    end else if (!legal_s) begin
                        state_r <= S_HALT;
                        illegal <= 1'b1;
                    end else begin
                        state_r <= S_EXE;
                    end
                end
                S_EXE: begin
                    if (is_branch_s) begin
                        state_r <= S_IF;
                    end else if (is_load_s || is_store_s) begin
                        state_r <= S_MEM;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_rdy) begin
                        state_r <= is_load_s ? S_WB : S_IF;
                    end else begin
                        state_r <= S_MEM;
                    end
                end
                S_WB:    state_r <= S_IF;
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_IF;
            endcase
        end
    end

    // Retired-instruction counter, bumped on the PC update that ends each instruction.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            inst_cnt <= {CNT_W{1'b0}};
        end else if (PCWre) begin
            inst_cnt <= inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            inst_cnt <= inst_cnt;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table of inputs and
// hand-computed control outputs, plus hand-written memory-wait and reset sequences.
module tb_multicycle_ctrl;

    logic        CLK;
    logic        Reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5, zero, lt, ltu, dmem_rdy;
    logic        PCWre, IRWre, RegWre, ExtSel, ALUSrcA, ALUSrcB, MemRd, MemWr, illegal;
    logic [1:0]  PCSrc, WBSel;
    logic [3:0]  ALUOp;
    logic [2:0]  state;
    logic [31:0] inst_cnt;

    multicycle_ctrl #(.HALT_OPCODE(7'h7f), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .dmem_rdy(dmem_rdy),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemRd(MemRd), .MemWr(MemWr),
        .WBSel(WBSel), .state(state), .illegal(illegal), .inst_cnt(inst_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One record per clock cycle: inputs applied that cycle and expected outputs.
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [2:0]  flg;   // {zero, lt, ltu}
        logic        rdy;
        logic [2:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    vec_t        vq[$];
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic        cur_f7;
    logic        e_ill;
    logic [31:0] e_cnt;
    int          n_chk;
    int          n_fail;

    function automatic logic [15:0] mk(input logic pcwre, input logic [1:0] pcsrc,
                                       input logic irwre, input logic regwre, input logic ext,
                                       input logic sa, input logic sb, input logic [3:0] aop,
                                       input logic mrd, input logic mwr, input logic [1:0] wbs);
        return {pcwre, pcsrc, irwre, regwre, ext, sa, sb, aop, mrd, mwr, wbs};
    endfunction

    function automatic logic [15:0] f_if();
        return mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
    endfunction

    function automatic logic [15:0] d(input logic ext, input logic sa, input logic sb,
                                      input logic [3:0] aop);
        return mk(1'b0, 2'd0, 1'b0, 1'b0, ext, sa, sb, aop, 1'b0, 1'b0, 2'd0);
    endfunction

    task automatic add(input logic rst, input logic [2:0] flg, input logic rdy,
                       input logic [2:0] st, input logic [15:0] c);
        vec_t v;
        v.rst = rst; v.op = cur_op; v.f3 = cur_f3; v.f7 = cur_f7; v.flg = flg; v.rdy = rdy;
        v.st = st; v.ctl = c; v.ill = e_ill; v.cnt = e_cnt;
        vq.push_back(v);
    endtask

    // IF/ID/EXE/WB instruction with the given decoded selects.
    task automatic alu_inst(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic ext, input logic sa, input logic sb, input logic [3:0] aop,
                            input logic [1:0] pcsrc, input logic [1:0] wbs);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(ext, sa, sb, aop));
        add(1'b1, 3'd0, 1'b0, 3'd2, d(ext, sa, sb, aop));
        add(1'b1, 3'd0, 1'b0, 3'd4, mk(1'b1, pcsrc, 1'b0, 1'b1, ext, sa, sb, aop, 1'b0, 1'b0, wbs));
        e_cnt = e_cnt + 32'd1;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [2:0] flg, input logic taken);
        cur_op = 7'h63; cur_f3 = f3; cur_f7 = 1'b0;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b0, 4'd1));
        add(1'b1, flg, 1'b0, 3'd2, mk(1'b1, {1'b0, taken}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,
                                      1'b0, 1'b0, 2'd0));
        e_cnt = e_cnt + 32'd1;
    endtask

    task automatic mem_inst(input logic is_ld, input int waits);
        cur_op = is_ld ? 7'h03 : 7'h23; cur_f3 = 3'b010; cur_f7 = 1'b0;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b1, 4'd0));
        add(1'b1, 3'd0, 1'b0, 3'd2, d(1'b1, 1'b0, 1'b1, 4'd0));
        for (int w = 0; w < waits; w++)
            add(1'b1, 3'd0, 1'b0, 3'd3, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,
                                           is_ld, ~is_ld, 2'd0));
        add(1'b1, 3'd0, 1'b1, 3'd3, mk(~is_ld, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,
                                       is_ld, ~is_ld, 2'd0));
        if (is_ld)
            add(1'b1, 3'd0, 1'b0, 3'd4, mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,
                                           1'b0, 1'b0, 2'd1));
        e_cnt = e_cnt + 32'd1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl_now();
        return 32'({PCWre, PCSrc, IRWre, RegWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                    MemRd, MemWr, WBSel});
    endfunction

    initial begin
        Reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; dmem_rdy = 1'b0;
        n_chk = 0; n_fail = 0; e_cnt = 32'd0; e_ill = 1'b0;
        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0;

        // ---------------- vector table ----------------
        add(1'b0, 3'd0, 1'b0, 3'd0, f_if());                                  // reset
        alu_inst(7'h13, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 2'd0);   // ADDI
        mem_inst(1'b1, 3);                                                    // LW, 3 waits
        mem_inst(1'b0, 1);                                                    // SW, 1 wait
        branch(3'b001, 3'b000, 1'b1);                                         // BNE zero=0
        branch(3'b001, 3'b100, 1'b0);                                         // BNE zero=1
        branch(3'b100, 3'b010, 1'b1);                                         // BLT lt=1
        branch(3'b111, 3'b001, 1'b0);                                         // BGEU ltu=1
        branch(3'b000, 3'b100, 1'b1);                                         // BEQ zero=1
        alu_inst(7'h37, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 2'd0, 2'd0);  // LUI
        alu_inst(7'h17, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd0, 2'd0);   // AUIPC
        alu_inst(7'h6f, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 2'd1, 2'd2);   // JAL
        alu_inst(7'h67, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd2, 2'd2);   // JALR
        alu_inst(7'h33, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 2'd0, 2'd0);   // SUB
        alu_inst(7'h33, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 2'd0, 2'd0);   // SRL
        alu_inst(7'h13, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 2'd0, 2'd0);   // SRAI
        alu_inst(7'h13, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 2'd0);   // ADDI, f7b5 ignored
        alu_inst(7'h13, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 2'd0, 2'd0);   // SLTIU
        alu_inst(7'h33, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 2'd0, 2'd0);   // AND
        // reset asserted during EXE of an ADDI
        cur_op = 7'h13; cur_f3 = 3'b000; cur_f7 = 1'b0;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b1, 4'd0));
        e_cnt = 32'd0;
        add(1'b0, 3'd0, 1'b0, 3'd0, f_if());
        alu_inst(7'h13, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 2'd0);
        // unsupported opcode
        cur_op = 7'h0b; cur_f3 = 3'b000;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b1, 4'd0));
        e_ill = 1'b1;
        add(1'b1, 3'b111, 1'b1, 3'd7, 16'd0);
        add(1'b1, 3'b111, 1'b1, 3'd7, 16'd0);
        e_ill = 1'b0; e_cnt = 32'd0;
        add(1'b0, 3'd0, 1'b0, 3'd0, f_if());
        // halt opcode
        cur_op = 7'h7f;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b1, 4'd0));
        add(1'b1, 3'b111, 1'b1, 3'd7, 16'd0);
        add(1'b1, 3'b111, 1'b1, 3'd7, 16'd0);
        add(1'b0, 3'd0, 1'b0, 3'd0, f_if());
        // branch with unsupported funct3
        cur_op = 7'h63; cur_f3 = 3'b010;
        add(1'b1, 3'd0, 1'b0, 3'd0, f_if());
        add(1'b1, 3'd0, 1'b0, 3'd1, d(1'b1, 1'b0, 1'b0, 4'd1));
        e_ill = 1'b1;
        add(1'b1, 3'd0, 1'b0, 3'd7, 16'd0);

        // ---------------- apply table ----------------
        foreach (vq[i]) begin
            @(negedge CLK);
            Reset = vq[i].rst; opcode = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7;
            {zero, lt, ltu} = vq[i].flg; dmem_rdy = vq[i].rdy;
            #2;
            chk("state", i, 32'(state), 32'(vq[i].st));
            chk("ctrl", i, ctl_now(), 32'(vq[i].ctl));
            chk("illegal", i, 32'(illegal), 32'(vq[i].ill));
            chk("inst_cnt", i, inst_cnt, vq[i].cnt);
        end

        // ---------------- store with long memory wait ----------------
        @(negedge CLK);
        Reset = 1'b0; opcode = 7'h23; funct3 = 3'b010; funct7b5 = 1'b0;
        {zero, lt, ltu} = 3'b000; dmem_rdy = 1'b0;
        #2 chk("sw_reset_state", 0, 32'(state), 32'd0);
        @(negedge CLK); Reset = 1'b1;   // IF
        @(negedge CLK);                 // ID
        @(negedge CLK);                 // EXE
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK); #2;
            chk("sw_wait", k, 32'({state, MemWr, MemRd, PCWre}), 32'({3'd3, 1'b1, 1'b0, 1'b0}));
        end
        dmem_rdy = 1'b1; #1;
        chk("sw_done", 0, 32'({state, MemWr, PCWre}), 32'({3'd3, 1'b1, 1'b1}));
        @(negedge CLK); dmem_rdy = 1'b0; #2;
        chk("sw_retired_state", 0, 32'(state), 32'd0);
        chk("sw_retired_cnt", 0, inst_cnt, 32'd1);

        // ---------------- reset in the middle of EXE ----------------
        opcode = 7'h13; funct3 = 3'b000;
        @(negedge CLK);                 // ID
        @(negedge CLK); #2;             // EXE
        chk("mid_exe_state", 0, 32'(state), 32'd2);
        #1 Reset = 1'b0; #1;
        chk("mid_exe_rst", 0, 32'({state, IRWre, PCWre}), 32'({3'd0, 1'b1, 1'b0}));
        chk("mid_exe_cnt", 0, inst_cnt, 32'd0);
        @(negedge CLK); Reset = 1'b1; #2;
        chk("rel_state", 0, 32'(state), 32'd0);
        @(negedge CLK); #2;
        chk("rel_next", 0, 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
